// File: rtl/reduction_pkg.sv
// Shared definitions for the bit-reduction pipeline: op encodings and helpers.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package reduction_pkg;

    localparam logic [1:0] OP_AND = 2'b00;
    localparam logic [1:0] OP_OR  = 2'b01;
    localparam logic [1:0] OP_XOR = 2'b10;

    // Identity element of the operator; the unused encoding 11 behaves as AND.
    function automatic logic op_identity(input logic [1:0] op);
        return (op == OP_OR || op == OP_XOR) ? 1'b0 : 1'b1;
    endfunction

    // Two-input application of the operator; 11 falls through to AND.
    function automatic logic op_combine(input logic [1:0] op, input logic a, input logic b);
        case (op)
            OP_OR:   return a | b;
            OP_XOR:  return a ^ b;
            default: return a & b;
        endcase
    endfunction

    // Number of nodes left after lvl rounds of radix-wide grouping.
    function automatic int level_width(input int dim, input int radix, input int lvl);
        int w;
        w = dim;
        for (int i = 0; i < lvl; i++) begin
            w = (w + radix - 1) / radix;
        end
        return w;
    endfunction

    // Tree depth: ceil(log_radix(dim)), never less than one register stage.
    function automatic int calc_levels(input int dim, input int radix);
        int w;
        int n;
        w = dim;
        n = 0;
        while (w > 1) begin
            w = (w + radix - 1) / radix;
            n++;
        end
        if (n < 1) begin
            n = 1;
        end
        return n;
    endfunction

endpackage

// File: rtl/reduction_stage.sv
// One tree level: reduces each RADIX-bit group of data_in with op_in and registers it.
// Latency: 1 cycle; data/op load only when v_in=1, v_out follows v_in every cycle.
// Backpressure: none, accepts a sample every cycle.
module reduction_stage
    import reduction_pkg::*;
#(
    parameter int IN_W  = 4,
    parameter int RADIX = 4,
    localparam int OUT_W = (IN_W + RADIX - 1) / RADIX
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             v_in,
    input  logic [0:IN_W-1]  data_in,
    input  logic [1:0]       op_in,
    output logic             v_out,
    output logic [0:OUT_W-1] data_out,
    output logic [1:0]       op_out
);

    localparam int PAD_W = OUT_W * RADIX;

    logic [0:PAD_W-1] padded;
    logic [0:OUT_W-1] reduced;

    // Pad the trailing group with the identity, then fold each group to one bit.
    always_comb begin
        logic acc;
        padded  = {PAD_W{op_identity(op_in)}};
        padded[0:IN_W-1] = data_in;
        reduced = '0;
        for (int g = 0; g < OUT_W; g++) begin
            acc = op_identity(op_in);
            for (int k = 0; k < RADIX; k++) begin
                acc = op_combine(op_in, acc, padded[g*RADIX+k]);
            end
            reduced[g] = acc;
        end
    end

    // Valid always advances; data and op hold unless a valid sample enters.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            v_out    <= 1'b0;
            data_out <= '0;
            op_out   <= OP_AND;
        end else begin
            v_out <= v_in;
            if (v_in) begin
                data_out <= reduced;
                op_out   <= op_in;
            end
        end
    end

endmodule

// File: rtl/reduction_pipe.sv
// Pipelined masked AND/OR/XOR reduction of a DIMENSION-bit flag vector via a radix-RADIX tree.
// Latency: LEVELS cycles in_valid->out_valid; out holds between results. Optional sticky flag: REDUCTION_STICKY_EN.
// Backpressure: none, one result per accepted input, in order, 1 sample/cycle.
module reduction_pipe
    import reduction_pkg::*;
#(
    parameter int DIMENSION = 3,
    parameter int RADIX     = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    input  logic [0:DIMENSION-1] in,
    input  logic [0:DIMENSION-1] mask,
    input  logic [1:0]           op,
    output logic                 out_valid,
    output logic                 out
`ifdef REDUCTION_STICKY_EN
    ,
    output logic                 sticky,
    input  logic                 sticky_clr
`endif
);

    localparam int LEVELS = calc_levels(DIMENSION, RADIX);

    logic [0:DIMENSION-1] masked;
    logic [1:0]           last_op_unused;

    // Excluded bits become the operator's identity so they cannot affect the result.
    always_comb begin
        masked = '0;
        for (int i = 0; i < DIMENSION; i++) begin
            masked[i] = mask[i] ? op_identity(op) : in[i];
        end
    end

    for (genvar l = 0; l < LEVELS; l++) begin : g_lvl
        localparam int IN_W  = level_width(DIMENSION, RADIX, l);
        localparam int OUT_W = level_width(DIMENSION, RADIX, l + 1);

        logic             v_in_l;
        logic [0:IN_W-1]  d_in_l;
        logic [1:0]       op_in_l;
        logic             v;
        logic [0:OUT_W-1] d;
        logic [1:0]       o;

        if (l == 0) begin : g_first
            assign v_in_l  = in_valid;
            assign d_in_l  = masked;
            assign op_in_l = op;
        end else begin : g_next
            assign v_in_l  = g_lvl[l-1].v;
            assign d_in_l  = g_lvl[l-1].d;
            assign op_in_l = g_lvl[l-1].o;
        end

        reduction_stage #(
            .IN_W  (IN_W),
            .RADIX (RADIX)
        ) u_stage (
            .clk      (clk),
            .rst_n    (rst_n),
            .v_in     (v_in_l),
            .data_in  (d_in_l),
            .op_in    (op_in_l),
            .v_out    (v),
            .data_out (d),
            .op_out   (o)
        );
    end

    // The final level is one bit wide, so out comes straight off a register.
    assign out_valid      = g_lvl[LEVELS-1].v;
    assign out            = g_lvl[LEVELS-1].d[0];
    assign last_op_unused = g_lvl[LEVELS-1].o;

`ifdef REDUCTION_STICKY_EN
    // Latch any true result; a same-cycle set beats the clear so no hit is lost.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sticky <= 1'b0;
        end else if (out_valid && out) begin
            sticky <= 1'b1;
        end else if (sticky_clr) begin
            sticky <= 1'b0;
        end
    end
`endif

endmodule
